// File: rtl/sc_level_timer.sv
// Game step timer: prescaled base tick, level-selected step period, step strobe and point counter.
// Optional macro SC_LEVEL_TIMER_SATURATE_EN makes the point counter saturate at 255 instead of wrapping.
module sc_level_timer #(
    parameter int unsigned PRESCALE_DIV = 50000,
    parameter int unsigned PERIOD_L1    = 500,
    parameter int unsigned PERIOD_L2    = 300,
    parameter int unsigned PERIOD_L3    = 150
) (
    input  logic       SC_LEVEL_TIMER_CLOCK_50,
    input  logic       SC_LEVEL_TIMER_RESET_InLow,
    input  logic       SC_LEVEL_TIMER_start_InLow,
    input  logic       SC_LEVEL_TIMER_clear_InLow,
    input  logic       SC_LEVEL_TIMER_hold_InLow,
    input  logic [1:0] SC_LEVEL_TIMER_level_InBUS,
    output logic       SC_LEVEL_TIMER_timer_OutLow,
    output logic [7:0] SC_LEVEL_TIMER_pointCounter_OutBUS,
    output logic       SC_LEVEL_TIMER_running_Out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE_DIV - 1);
    localparam logic [9:0]  L1_LAST    = 10'(PERIOD_L1 - 1);
    localparam logic [9:0]  L2_LAST    = 10'(PERIOD_L2 - 1);
    localparam logic [9:0]  L3_LAST    = 10'(PERIOD_L3 - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] presc;
    logic [15:0] presc_next;
    logic [9:0]  step;
    logic [9:0]  step_next;
    logic [7:0]  points;
    logic [7:0]  points_next;
    logic [7:0]  points_inc;
    logic [9:0]  period_last;
    logic        strobe_next;
    logic        base_tick;
    logic        terminal;

    always_comb begin
        unique case (SC_LEVEL_TIMER_level_InBUS)
            2'b10:   period_last = L2_LAST;
            2'b11:   period_last = L3_LAST;
            default: period_last = L1_LAST;
        endcase
    end

    // Using >= lets a level change to a shorter period terminate at the very next tick.
    assign base_tick = (state == ST_RUN) && (presc == PRESC_LAST);
    assign terminal  = base_tick && (step >= period_last);

`ifdef SC_LEVEL_TIMER_SATURATE_EN
    assign points_inc = (points == 8'hFF) ? points : points + 8'd1;
`else
    assign points_inc = points + 8'd1;
`endif

    always_comb begin
        state_next = state;
        if (!SC_LEVEL_TIMER_clear_InLow) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (!SC_LEVEL_TIMER_start_InLow) state_next = ST_RUN;
                ST_RUN:  if (!SC_LEVEL_TIMER_hold_InLow)  state_next = ST_HOLD;
                ST_HOLD: if (SC_LEVEL_TIMER_hold_InLow)   state_next = ST_RUN;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Counters only move while the registered state is RUN; HOLD freezes them in place.
    always_comb begin
        presc_next  = presc;
        step_next   = step;
        points_next = points;
        strobe_next = 1'b0;
        if (!SC_LEVEL_TIMER_clear_InLow || state == ST_IDLE) begin
            presc_next  = '0;
            step_next   = '0;
            points_next = '0;
        end else if (state == ST_RUN) begin
            presc_next = base_tick ? 16'd0 : presc + 16'd1;
            if (terminal) begin
                step_next   = '0;
                strobe_next = 1'b1;
                points_next = points_inc;
            end else if (base_tick) begin
                step_next = step + 10'd1;
            end
        end
    end

    always_ff @(posedge SC_LEVEL_TIMER_CLOCK_50 or negedge SC_LEVEL_TIMER_RESET_InLow) begin
        if (!SC_LEVEL_TIMER_RESET_InLow) begin
            state                              <= ST_IDLE;
            presc                              <= '0;
            step                               <= '0;
            points                             <= '0;
            SC_LEVEL_TIMER_timer_OutLow        <= 1'b1;
            SC_LEVEL_TIMER_running_Out         <= 1'b0;
        end else begin
            state                              <= state_next;
            presc                              <= presc_next;
            step                               <= step_next;
            points                             <= points_next;
            SC_LEVEL_TIMER_timer_OutLow        <= ~strobe_next;
            SC_LEVEL_TIMER_running_Out         <= (state_next == ST_RUN);
        end
    end

    assign SC_LEVEL_TIMER_pointCounter_OutBUS = points;

endmodule

// File: tb/tb_sc_level_timer.sv
// Directed bench for sc_level_timer with a cycle-level reference model and literal interval checks.
module tb_sc_level_timer;

    localparam int DIV = 4;
    localparam int P1  = 3;
    localparam int P2  = 2;
    localparam int P3  = 1;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start_n = 1'b1;
    logic       clear_n = 1'b1;
    logic       hold_n  = 1'b1;
    logic [1:0] level   = 2'b00;
    logic       timer_n;
    logic [7:0] points;
    logic       running;

    int n_checks = 0;
    int n_fail   = 0;

    sc_level_timer #(
        .PRESCALE_DIV(DIV),
        .PERIOD_L1(P1),
        .PERIOD_L2(P2),
        .PERIOD_L3(P3)
    ) dut (
        .SC_LEVEL_TIMER_CLOCK_50(clk),
        .SC_LEVEL_TIMER_RESET_InLow(rst_n),
        .SC_LEVEL_TIMER_start_InLow(start_n),
        .SC_LEVEL_TIMER_clear_InLow(clear_n),
        .SC_LEVEL_TIMER_hold_InLow(hold_n),
        .SC_LEVEL_TIMER_level_InBUS(level),
        .SC_LEVEL_TIMER_timer_OutLow(timer_n),
        .SC_LEVEL_TIMER_pointCounter_OutBUS(points),
        .SC_LEVEL_TIMER_running_Out(running)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode, RUN cycles into the current base tick, completed ticks in this step.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    int m_mode   = M_IDLE;
    int m_cyc    = 0;
    int m_ticks  = 0;
    int m_pc     = 0;
    bit m_strobe = 1'b0;

    function automatic int period_of(input logic [1:0] lv);
        case (lv)
            2'b10:   return P2;
            2'b11:   return P3;
            default: return P1;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_cyc = 0; m_ticks = 0; m_pc = 0; m_strobe = 1'b0;
        end else begin
            m_strobe = 1'b0;
            if (!clear_n) begin
                m_mode = M_IDLE; m_cyc = 0; m_ticks = 0; m_pc = 0;
            end else if (m_mode == M_IDLE) begin
                if (!start_n) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                m_cyc++;
                if (m_cyc == DIV) begin
                    m_cyc = 0;
                    m_ticks++;
                    if (m_ticks >= period_of(level)) begin
                        m_ticks  = 0;
                        m_strobe = 1'b1;
`ifdef SC_LEVEL_TIMER_SATURATE_EN
                        if (m_pc < 255) m_pc++;
`else
                        m_pc = (m_pc + 1) % 256;
`endif
                    end
                end
                if (!hold_n) m_mode = M_HOLD;
            end else begin
                if (hold_n) m_mode = M_RUN;
            end
        end
    end

    // Scoreboard compare on every falling edge
    always @(negedge clk) begin
        check("model_timer", 32'(timer_n), 32'(!m_strobe));
        check("model_points", 32'(points), 32'(m_pc));
        check("model_running", 32'(running), 32'(m_mode == M_RUN));
    end

    // Driver tasks
    task automatic pulse_start();
        start_n = 1'b0;
        @(negedge clk);
        start_n = 1'b1;
    endtask

    task automatic wait_strobe(input string name, input int exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (timer_n !== 1'b0 && n < 2000);
        check(name, 32'(n), 32'(exp));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_timer", 32'(timer_n), 32'd1);
        check("reset_points", 32'(points), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_running", 32'(running), 32'd0);

        // Level 1: 12-cycle steps
        level = 2'b00;
        pulse_start();
        check("run_entry", 32'(running), 32'd1);
        wait_strobe("l1_first", 12);
        check("l1_pc1", 32'(points), 32'd1);
        wait_strobe("l1_second", 12);
        check("l1_pc2", 32'(points), 32'd2);
        wait_strobe("l1_third", 12);
        check("l1_pc3", 32'(points), 32'd3);

        // L1 -> L3 with step counter already past the new terminal count
        repeat (5) @(negedge clk);
        level = 2'b11;
        wait_strobe("l1_to_l3", 3);
        check("pc4", 32'(points), 32'd4);
        wait_strobe("l3_a", 4);
        wait_strobe("l3_b", 4);
        check("pc6", 32'(points), 32'd6);

        // Start while running has no effect
        pulse_start();
        wait_strobe("start_ignored", 3);
        check("pc7", 32'(points), 32'd7);

        // L3 -> L1 mid-period: full L1 step counted from the last strobe
        repeat (2) @(negedge clk);
        level = 2'b01;
        wait_strobe("l3_to_l1", 10);
        check("pc8", 32'(points), 32'd8);

        // Hold for 7 cycles delays the strobe by exactly 7
        repeat (5) @(negedge clk);
        hold_n = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("hold_no_strobe", 32'(timer_n), 32'd1);
        end
        hold_n = 1'b1;
        wait_strobe("hold_delay", 7);
        check("pc9", 32'(points), 32'd9);
        wait_strobe("after_hold", 12);
        check("pc10", 32'(points), 32'd10);

        // Level 2: 8-cycle steps
        level = 2'b10;
        wait_strobe("l2_first", 8);
        wait_strobe("l2_second", 8);
        check("pc12", 32'(points), 32'd12);
        level = 2'b00;
        wait_strobe("l2_to_l1", 12);

        // Clear coincident with terminal count
        repeat (11) @(negedge clk);
        clear_n = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        check("clear_timer", 32'(timer_n), 32'd1);
        check("clear_points", 32'(points), 32'd0);
        check("clear_running", 32'(running), 32'd0);
        repeat (20) @(negedge clk);
        check("clear_stays_idle", 32'(running), 32'd0);

        // 256 strobes at level 3
        level = 2'b11;
        pulse_start();
        for (int i = 0; i < 255; i++) wait_strobe("l3_run", 4);
        check("pc255", 32'(points), 32'd255);
        wait_strobe("l3_run_last", 4);
`ifdef SC_LEVEL_TIMER_SATURATE_EN
        check("pc_overflow", 32'(points), 32'd255);
`else
        check("pc_overflow", 32'(points), 32'd0);
`endif
        wait_strobe("l3_after_overflow", 4);
`ifdef SC_LEVEL_TIMER_SATURATE_EN
        check("pc_after_overflow", 32'(points), 32'd255);
`else
        check("pc_after_overflow", 32'(points), 32'd1);
`endif

        // Asynchronous reset while the strobe is low
        #2;
        rst_n = 1'b0;
        #1;
        check("async_timer", 32'(timer_n), 32'd1);
        check("async_points", 32'(points), 32'd0);
        check("async_running", 32'(running), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle", 32'(running), 32'd0);
        check("post_reset_points", 32'(points), 32'd0);
        level = 2'b00;
        pulse_start();
        wait_strobe("restart", 12);
        check("restart_pc", 32'(points), 32'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
